// File: rtl/payload_fcs_checker.sv
// Payload stage of a frame receiver: counts payload+FCS bytes, runs a reflected
// CRC-32 over them and reports one registered verdict pulse per completed frame.
module payload_fcs_checker #(
  parameter int unsigned MIN_PAYLOAD = 46,
  parameter int unsigned MAX_PAYLOAD = 1500
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic [7:0]  data_i,
  input  logic        control_i,
  input  logic [15:0] type_length_i,
  output logic        packet_size_valid_o,
  output logic        size_error_o,
  output logic        fcs_error_o,
  output logic [10:0] byte_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REF = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB_20E3;
  localparam logic [15:0] MIN_LEN      = 16'(MIN_PAYLOAD);
  localparam logic [15:0] MAX_LEN      = 16'(MAX_PAYLOAD);
  localparam logic [15:0] TL_LEN_MAX   = 16'd1500;
  localparam logic [10:0] COUNT_SAT    = 11'd2047;

  state_e      state_q, state_d;
  logic [10:0] count_q, count_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] tl_q, tl_d;
  logic        valid_q, valid_d;
  logic        size_err_q, size_err_d;
  logic        fcs_err_q, fcs_err_d;

  // LSB-first CRC-32 step over one byte, register kept un-inverted.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC_POLY_REF;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  // Values above 1500 are EtherTypes, so only the range check applies to them.
  function automatic logic size_legal(input logic [10:0] cnt, input logic [15:0] tl);
    logic [15:0] pay;
    logic [15:0] exp_len;
    logic        ok;
    pay     = {5'd0, cnt} - 16'd4;
    exp_len = (tl < MIN_LEN) ? MIN_LEN : tl;
    if ((cnt < 11'd4) || (cnt == COUNT_SAT)) begin
      ok = 1'b0;
    end else if ((pay < MIN_LEN) || (pay > MAX_LEN)) begin
      ok = 1'b0;
    end else if (tl <= TL_LEN_MAX) begin
      ok = (pay == exp_len);
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

  // Next-state, datapath and verdict logic.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    crc_d      = crc_q;
    tl_d       = tl_q;
    valid_d    = 1'b0;
    size_err_d = 1'b0;
    fcs_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i && control_i) begin
          state_d = RUN;
          count_d = 11'd1;
          crc_d   = crc32_byte(CRC_INIT, data_i);
          tl_d    = type_length_i;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (control_i) begin
          count_d = (count_q == COUNT_SAT) ? count_q : (count_q + 11'd1);
          crc_d   = crc32_byte(crc_q, data_i);
        end else begin
          state_d = DONE;
          if (!size_legal(count_q, tl_q)) begin
            size_err_d = 1'b1;
          end else if (crc_q != CRC_RESIDUE) begin
            fcs_err_d = 1'b1;
          end else begin
            valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      count_q    <= 11'd0;
      crc_q      <= CRC_INIT;
      tl_q       <= 16'd0;
      valid_q    <= 1'b0;
      size_err_q <= 1'b0;
      fcs_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      crc_q      <= crc_d;
      tl_q       <= tl_d;
      valid_q    <= valid_d;
      size_err_q <= size_err_d;
      fcs_err_q  <= fcs_err_d;
    end
  end

  assign packet_size_valid_o = valid_q;
  assign size_error_o        = size_err_q;
  assign fcs_error_o         = fcs_err_q;
  assign byte_count_o        = count_q;

endmodule

// File: tb/tb_payload_fcs_checker.sv
// Directed bench for payload_fcs_checker: builds frames with a bench-side FCS
// generator and checks byte count and verdict pulses against hand-derived values.
module tb_payload_fcs_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        control;
  logic [7:0]  data;
  logic [15:0] tl;
  logic        psv, serr, ferr;
  logic [10:0] cnt;
  logic [2:0]  pulses;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  payload_fcs_checker dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .enable_i            (enable),
    .data_i              (data),
    .control_i           (control),
    .type_length_i       (tl),
    .packet_size_valid_o (psv),
    .size_error_o        (serr),
    .fcs_error_o         (ferr),
    .byte_count_o        (cnt)
  );

  assign pulses = {psv, serr, ferr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bit-serial reference CRC (reflected 0xEDB88320 form).
  function automatic logic [31:0] ref_crc(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int k = 0; k < 8; k++) begin
      fb = c[0] ^ d[k];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB8_8320;
    end
    return c;
  endfunction

  // Payload byte i is i mod 256; FCS appended LSB first as the inverted CRC.
  task automatic send_bytes(input logic [15:0] tl_v, input int n_pay,
                            input bit flip_fcs, input bit with_fcs);
    logic [7:0]  q[$];
    logic [31:0] c;
    logic [31:0] fcs;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n_pay; i++) begin
      q.push_back(8'(i));
      c = ref_crc(c, 8'(i));
    end
    if (with_fcs) begin
      fcs = ~c;
      q.push_back(fcs[7:0]);
      q.push_back(fcs[15:8]);
      q.push_back(fcs[23:16]);
      q.push_back(fcs[31:24]);
      if (flip_fcs) q[q.size()-1] = q[q.size()-1] ^ 8'h01;
    end
    tl = tl_v;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      enable  = 1'b1;
      control = 1'b1;
      data    = q[i];
    end
  endtask

  task automatic finish_frame(input string tag, input logic [10:0] exp_cnt, input logic [2:0] exp_p);
    @(negedge clk);
    check({tag, "_pre"}, {29'd0, pulses}, 32'd0);
    control = 1'b0;
    data    = 8'hA5;
    @(negedge clk);
    check({tag, "_pulse"}, {29'd0, pulses}, {29'd0, exp_p});
    check({tag, "_count"}, {21'd0, cnt}, {21'd0, exp_cnt});
    enable = 1'b0;
    @(negedge clk);
    check({tag, "_clear"}, {29'd0, pulses}, 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b0;
    control = 1'b0;
    data    = 8'h00;
    tl      = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_pulses", {29'd0, pulses}, 32'd0);
    check("rst_count", {21'd0, cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Minimum-size frame with matching length field.
    send_bytes(16'h002E, 46, 1'b0, 1'b1);
    finish_frame("good46", 11'd50, 3'b100);

    // Maximum EtherType frame and one byte over.
    send_bytes(16'h0800, 1500, 1'b0, 1'b1);
    finish_frame("good1500", 11'd1504, 3'b100);
    send_bytes(16'h0800, 1501, 1'b0, 1'b1);
    finish_frame("over1501", 11'd1505, 3'b010);

    // Corrupted FCS, length mismatch, and size taking priority over FCS.
    send_bytes(16'h002E, 46, 1'b1, 1'b1);
    finish_frame("badfcs", 11'd50, 3'b001);
    send_bytes(16'h0030, 46, 1'b0, 1'b1);
    finish_frame("lenmis", 11'd50, 3'b010);
    send_bytes(16'h0030, 46, 1'b1, 1'b1);
    finish_frame("prio", 11'd50, 3'b010);

    // Short length field padded to minimum, EtherType at minimum, runt, tiny.
    send_bytes(16'h0010, 46, 1'b0, 1'b1);
    finish_frame("pad16", 11'd50, 3'b100);
    send_bytes(16'h0800, 46, 1'b0, 1'b1);
    finish_frame("etype46", 11'd50, 3'b100);
    send_bytes(16'h0800, 45, 1'b0, 1'b1);
    finish_frame("runt45", 11'd49, 3'b010);
    send_bytes(16'h0800, 3, 1'b0, 1'b0);
    finish_frame("tiny3", 11'd3, 3'b010);

    // Abort after 20 bytes: no pulse, count holds, then a fresh good frame.
    send_bytes(16'h002E, 20, 1'b0, 1'b0);
    @(negedge clk);
    enable  = 1'b0;
    control = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_nopulse", {29'd0, pulses}, 32'd0);
    end
    check("abort_count", {21'd0, cnt}, 32'd20);
    send_bytes(16'h002E, 46, 1'b0, 1'b1);
    finish_frame("after_abort", 11'd50, 3'b100);

    // Asynchronous reset between edges in the middle of a frame.
    send_bytes(16'h002E, 10, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", {21'd0, cnt}, 32'd0);
    check("arst_pulses", {29'd0, pulses}, 32'd0);
    repeat (2) @(negedge clk);
    check("arst_held", {21'd0, cnt}, 32'd0);
    enable  = 1'b0;
    control = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    send_bytes(16'h002E, 46, 1'b0, 1'b1);
    finish_frame("after_rst", 11'd50, 3'b100);

    // Oversized frame saturates the counter.
    send_bytes(16'h0800, 2096, 1'b0, 1'b1);
    finish_frame("sat2100", 11'd2047, 3'b010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
